// File: rtl/dfr_reservoir_capture_pkg.sv
// Shared types and constants for the DFR reservoir/capture engine.
package dfr_reservoir_capture_pkg;

    // Capture control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Capture mode encodings, as seen on the mode input.
    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CIRC   = 1'b1;

endpackage : dfr_reservoir_capture_pkg

// File: rtl/dfr_reservoir_capture_sat_add.sv
// Saturating feedback adder: sum = clamp(din + (tail >>> FB_SHIFT)).
// Purely combinational so it can be exercised on its own.
module dfr_sat_add #(
    parameter int DATA_WIDTH = 32,
    parameter int FB_SHIFT   = 1
) (
    input  logic signed [DATA_WIDTH-1:0] din_i,
    input  logic signed [DATA_WIDTH-1:0] tail_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] fb;
    logic        [DATA_WIDTH:0]   full;

    assign fb   = tail_i >>> FB_SHIFT;
    // One extra bit of headroom: the two top bits disagree exactly on overflow.
    assign full = {din_i[DATA_WIDTH-1], din_i} + {fb[DATA_WIDTH-1], fb};

    // Clamp to the representable range when the extended sum overflows.
    always_comb begin
        if (full[DATA_WIDTH] != full[DATA_WIDTH-1]) begin
            sum_o = full[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            sum_o = full[DATA_WIDTH-1:0];
        end
    end

endmodule : dfr_sat_add

// File: rtl/dfr_reservoir_capture.sv
// DFR reservoir and capture engine: a virtual-node delay loop with attenuated,
// saturating feedback, whose node values are recorded into a history RAM under
// start/stop control, with a live 1-cycle readback port.
module dfr_reservoir_capture
    import dfr_reservoir_capture_pkg::*;
#(
    parameter int VIRTUAL_NODES   = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int HIST_ADDR_WIDTH = 10,
    parameter int FB_SHIFT        = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       mode,
    input  logic [HIST_ADDR_WIDTH:0]   num_samples,
    input  logic                       din_valid,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic                       din_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       wrapped,
    output logic [HIST_ADDR_WIDTH-1:0] wr_ptr,
    input  logic [HIST_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << HIST_ADDR_WIDTH;
    localparam int CW    = HIST_ADDR_WIDTH + 1;

    state_e                       state_q, state_d;
    logic                         mode_q, mode_d;
    logic [CW-1:0]                num_q, num_d;
    logic [CW-1:0]                count_q, count_d;
    logic [HIST_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                         wrapped_q, wrapped_d;
    logic                         busy_q, done_q;
    logic [DATA_WIDTH-1:0]        rd_data_q;

    logic signed [DATA_WIDTH-1:0] dl_q [VIRTUAL_NODES];
    logic signed [DATA_WIDTH-1:0] node;
    logic                         accept;
    logic                         wr_en;
    logic                         clear_loop;

    logic [DATA_WIDTH-1:0]        hist_mem [DEPTH];

    // busy_q is the registered RUN indication, so it doubles as din_ready.
    assign accept = din_valid & busy_q;

    dfr_sat_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .FB_SHIFT   (FB_SHIFT)
    ) u_sat_add (
        .din_i  ($signed(din)),
        .tail_i (dl_q[VIRTUAL_NODES-1]),
        .sum_o  (node)
    );

    // Next-state logic for the capture controller and its bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        num_d      = num_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        wrapped_d  = wrapped_q;
        wr_en      = 1'b0;
        clear_loop = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // start wins over a coincident stop outside RUN.
                if (start) begin
                    state_d    = ST_RUN;
                    mode_d     = mode;
                    num_d      = (num_samples == '0) ? CW'(DEPTH) : num_samples;
                    count_d    = '0;
                    wr_ptr_d   = '0;
                    wrapped_d  = 1'b0;
                    clear_loop = 1'b1;
                end
            end
            ST_RUN: begin
                // start is ignored here; stop wins and still lets this accept land.
                if (accept) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + HIST_ADDR_WIDTH'(1);
                    if (mode_q == MODE_CIRC && wr_ptr_q == HIST_ADDR_WIDTH'(DEPTH - 1)) begin
                        wrapped_d = 1'b1;
                    end
                    if (mode_q == MODE_SINGLE) begin
                        count_d = count_q + CW'(1);
                        if (count_d == num_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                if (stop) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_SINGLE;
            num_q     <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= state_d;
            mode_q    <= mode_d;
            num_q     <= num_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            wrapped_q <= wrapped_d;
            busy_q    <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    // Virtual-node delay loop: newest node at index 0, tail at the far end.
    always_ff @(posedge clk) begin
        if (rst || clear_loop) begin
            for (int i = 0; i < VIRTUAL_NODES; i++) begin
                dl_q[i] <= '0;
            end
        end else if (wr_en) begin
            dl_q[0] <= node;
            for (int i = 1; i < VIRTUAL_NODES; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    // History RAM write port; a reset cycle never writes.
    always_ff @(posedge clk) begin
        // NOTE: the history array has no reset so it maps onto RAM and survives rst.
        if (wr_en && !rst) begin
            hist_mem[wr_ptr_q] <= node;
        end
    end

    // Registered readback; a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= hist_mem[rd_addr];
        end
    end

    assign din_ready = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrapped   = wrapped_q;
    assign wr_ptr    = wr_ptr_q;
    assign rd_data   = rd_data_q;

endmodule : dfr_reservoir_capture

// File: tb/tb_dfr_reservoir_capture.sv
// Self-checking bench: two instances (4 and 1 virtual nodes) share clk/rst.
// A behavioural model predicts history contents and status; readback
// expectations go to a scoreboard queue drained by an independent monitor.
module tb_dfr_reservoir_capture;

    localparam int DW    = 32;
    localparam int HAW   = 3;
    localparam int DEPTH = 8;
    localparam int FB    = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           start [2];
    logic           stop [2];
    logic           mode [2];
    logic           din_valid [2];
    logic           din_ready [2];
    logic           busy [2];
    logic           done [2];
    logic           wrapped [2];
    logic [HAW:0]   num_samples [2];
    logic [DW-1:0]  din [2];
    logic [DW-1:0]  rd_data [2];
    logic [HAW-1:0] wr_ptr [2];
    logic [HAW-1:0] rd_addr [2];
    logic           rd_req [2];

    dfr_reservoir_capture #(
        .VIRTUAL_NODES(4), .DATA_WIDTH(DW), .HIST_ADDR_WIDTH(HAW), .FB_SHIFT(FB)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .mode(mode[0]),
        .num_samples(num_samples[0]), .din_valid(din_valid[0]), .din(din[0]),
        .din_ready(din_ready[0]), .busy(busy[0]), .done(done[0]), .wrapped(wrapped[0]),
        .wr_ptr(wr_ptr[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0])
    );

    dfr_reservoir_capture #(
        .VIRTUAL_NODES(1), .DATA_WIDTH(DW), .HIST_ADDR_WIDTH(HAW), .FB_SHIFT(FB)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .mode(mode[1]),
        .num_samples(num_samples[1]), .din_valid(din_valid[1]), .din(din[1]),
        .din_ready(din_ready[1]), .busy(busy[1]), .done(done[1]), .wrapped(wrapped[1]),
        .wr_ptr(wr_ptr[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} m_state_e;

    m_state_e      m_state [2];
    int            m_ptr [2];
    bit            m_wrapped [2];
    bit            m_mode [2];
    int            m_num [2];
    int            m_count [2];
    logic [DW-1:0] m_hist [2][DEPTH];
    bit            m_hist_v [2][DEPTH];
    int            m_nodes [2][256];
    int            m_n [2];
    int            vn [2] = '{4, 1};

    function automatic int sat_ref(input int d, input int t);
        longint maxv = 2147483647;
        longint minv = -maxv - 1;
        longint s;
        s = longint'(d) + (longint'(t) >>> FB);
        if (s > maxv) s = maxv;
        if (s < minv) s = minv;
        return int'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i]   = M_IDLE;
            m_ptr[i]     = 0;
            m_wrapped[i] = 1'b0;
            m_n[i]       = 0;
            m_count[i]   = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit v, input logic [DW-1:0] d,
                              input bit st, input bit sp);
        int tail;
        int node;
        if (m_state[i] != M_RUN) begin
            if (st) begin
                m_state[i]   = M_RUN;
                m_ptr[i]     = 0;
                m_wrapped[i] = 1'b0;
                m_n[i]       = 0;
                m_count[i]   = 0;
                m_mode[i]    = mode[i];
                m_num[i]     = (num_samples[i] == 0) ? DEPTH : int'(num_samples[i]);
            end
        end else begin
            if (v) begin
                tail = 0;
                if (m_n[i] >= vn[i]) tail = m_nodes[i][m_n[i] - vn[i]];
                node = sat_ref(int'(d), tail);
                m_nodes[i][m_n[i]] = node;
                m_n[i]++;
                m_hist[i][m_ptr[i]]   = node;
                m_hist_v[i][m_ptr[i]] = 1'b1;
                if (m_mode[i] && m_ptr[i] == DEPTH - 1) m_wrapped[i] = 1'b1;
                m_ptr[i] = (m_ptr[i] + 1) % DEPTH;
                m_count[i]++;
                if (!m_mode[i] && m_count[i] == m_num[i]) m_state[i] = M_DONE;
            end
            if (sp) m_state[i] = M_DONE;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int            inst;
        logic [DW-1:0] exp;
        string         name;
    } rd_exp_t;

    rd_exp_t sb_q [$];

    task automatic push_rd(input int i, input int ra, input logic [DW-1:0] exp, input string name);
        rd_exp_t e;
        rd_addr[i] = ra[HAW-1:0];
        rd_req[i]  = 1'b1;
        e.inst = i;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // One clock of stimulus on instance i, optionally with a readback request.
    task automatic cycle(input int i, input bit v, input logic [DW-1:0] d, input bit st,
                         input bit sp, input bit rd_en, input int ra);
        din_valid[i] = v;
        din[i]       = d;
        start[i]     = st;
        stop[i]      = sp;
        if (rd_en) push_rd(i, ra, m_hist[i][ra], $sformatf("rd%0d[%0d]", i, ra));
        model_edge(i, v, d, st, sp);
        @(posedge clk); #1;
        din_valid[i] = 1'b0;
        start[i]     = 1'b0;
        stop[i]      = 1'b0;
        rd_req[i]    = 1'b0;
    endtask

    // Readback against a value pinned independently of the model.
    task automatic rd_const(input int i, input int ra, input logic [DW-1:0] exp, input string name);
        push_rd(i, ra, exp, name);
        @(posedge clk); #1;
        rd_req[i] = 1'b0;
    endtask

    task automatic check_status(input int i, input string tag);
        check({tag, "_busy"},    busy[i],      m_state[i] == M_RUN);
        check({tag, "_done"},    done[i],      m_state[i] == M_DONE);
        check({tag, "_ready"},   din_ready[i], m_state[i] == M_RUN);
        check({tag, "_wrapped"}, wrapped[i],   m_wrapped[i]);
        check({tag, "_wr_ptr"},  wr_ptr[i],    m_ptr[i]);
    endtask

    task automatic read_all_written(input int i, input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            if (m_hist_v[i][a]) cycle(i, 0, '0, 0, 0, 1, a);
        end
        check_status(i, tag);
    endtask

    // Monitor: a request seen at a rising edge is answered on rd_data after it.
    initial begin
        bit p0, p1;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            p0 = rd_req[0];
            p1 = rd_req[1];
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 && p0) || (k == 1 && p1)) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check(e.name, rd_data[e.inst], e.exp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] sat_seq [5];
        int            num_r;

        for (int i = 0; i < 2; i++) begin
            start[i] = 0; stop[i] = 0; mode[i] = 0; num_samples[i] = '0;
            din_valid[i] = 1; din[i] = '0; rd_addr[i] = '0; rd_req[i] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_hist[i][a]   = '0;
                m_hist_v[i][a] = 1'b0;
            end
        end

        // 1: reset held two cycles with din_valid asserted.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check_status(i, $sformatf("reset%0d", i));
            check($sformatf("reset%0d_rd_data", i), rd_data[i], 0);
        end
        rst = 1'b0;
        din_valid[0] = 0;
        din_valid[1] = 0;

        // 2: single-shot of five constant samples.
        mode[0] = 0; num_samples[0] = 5;
        cycle(0, 0, '0, 1, 0, 0, 0);
        check_status(0, "ss_start");
        for (int k = 0; k < 6; k++) begin
            cycle(0, 1, 100, 0, 0, 0, 0);
            check_status(0, $sformatf("ss_acc%0d", k));
        end
        rd_const(0, 4, 150, "ss_hist4");
        rd_const(0, 0, 100, "ss_hist0");
        read_all_written(0, "ss_rd");

        // 2b: num_samples=0 means full depth; stop lands on the final accept.
        mode[0] = 0; num_samples[0] = 0;
        cycle(0, 0, '0, 1, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            cycle(0, 1, $urandom, 0, (k == 7), 0, 0);
            check_status(0, $sformatf("full_acc%0d", k));
        end
        read_all_written(0, "full_rd");

        // 3: circular, ten accepts of 1..10.
        mode[0] = 1;
        cycle(0, 0, '0, 1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cycle(0, 1, k, 0, 0, 0, 0);
            check_status(0, $sformatf("circ_acc%0d", k));
        end
        rd_const(0, 0, 11, "circ_hist0");
        // Same-address write and read in one cycle returns the previous lap.
        cycle(0, 1, $urandom, 0, 0, 1, m_ptr[0]);
        check_status(0, "circ_rw");
        read_all_written(0, "circ_rd");
        cycle(0, 0, '0, 0, 1, 0, 0);
        check_status(0, "circ_stop");

        // 4: saturation on the single-node instance.
        sat_seq = '{32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        mode[1] = 1; num_samples[1] = 0;
        cycle(1, 0, '0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 1, sat_seq[k], 0, 0, 0, 0);
        rd_const(1, 1, 32'h7FFF_FFFF, "sat_hi");
        rd_const(1, 4, 32'h8000_0000, "sat_lo");
        read_all_written(1, "sat_rd");
        for (int k = 0; k < 24; k++) begin
            int ra = $urandom_range(0, DEPTH - 1);
            logic [DW-1:0] d;
            case ($urandom_range(0, 3))
                0: d = 32'h7FFF_FFFF;
                1: d = 32'h8000_0000;
                default: d = $urandom;
            endcase
            cycle(1, ($urandom_range(0, 3) != 0), d, 0, 0, m_hist_v[1][ra], ra);
        end
        check_status(1, "sat_rand");
        cycle(1, 0, '0, 0, 1, 0, 0);
        check_status(1, "sat_stop");

        // 5: control corner cases.
        mode[0] = 0; num_samples[0] = 8;
        cycle(0, 0, '0, 1, 0, 0, 0);
        cycle(0, 1, $urandom, 0, 0, 0, 0);
        cycle(0, 1, $urandom, 0, 0, 0, 0);
        cycle(0, 0, '0, 1, 0, 0, 0);
        check_status(0, "ctl_start_in_run");
        cycle(0, 1, $urandom, 0, 1, 0, 0);
        check_status(0, "ctl_stop_acc3");
        cycle(0, 0, '0, 0, 1, 0, 0);
        check_status(0, "ctl_stop_in_done");
        cycle(0, 0, '0, 1, 1, 0, 0);
        check_status(0, "ctl_restart");
        for (int k = 0; k < 5; k++) cycle(0, 1, $urandom, 0, 0, 0, 0);
        check_status(0, "ctl_refill");
        read_all_written(0, "ctl_rd");
        cycle(0, 0, '0, 1, 1, 0, 0);
        check_status(0, "ctl_stop_wins");

        // 6: reset mid-run keeps history readable.
        mode[0] = 0; num_samples[0] = 8;
        cycle(0, 0, '0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, $urandom, 0, 0, 0, 0);
        rst = 1'b1;
        din_valid[0] = 1'b1;
        din[0] = $urandom;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        check_status(0, "rst_mid");
        for (int a = 0; a < 4; a++) begin
            cycle(0, 1, $urandom, 0, 0, 1, a);
            check_status(0, $sformatf("rst_rd%0d", a));
        end

        // Random circular and single-shot runs with gaps and stray starts.
        mode[0] = 1;
        cycle(0, 0, '0, 1, 0, 0, 0);
        for (int k = 0; k < 60; k++) begin
            int ra = $urandom_range(0, DEPTH - 1);
            cycle(0, ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 9) == 0), 0,
                  m_hist_v[0][ra], ra);
            check_status(0, "rnd_circ");
        end
        cycle(0, 0, '0, 0, 1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            num_r = $urandom_range(1, DEPTH);
            mode[0] = 0; num_samples[0] = num_r[HAW:0];
            cycle(0, 0, '0, 1, 0, 0, 0);
            for (int k = 0; k < 12; k++) begin
                cycle(0, ($urandom_range(0, 2) != 0), $urandom, 0, 0, 0, 0);
                check_status(0, $sformatf("rnd_ss%0d", r));
            end
            read_all_written(0, $sformatf("rnd_ss_rd%0d", r));
        end

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dfr_reservoir_capture
